dm_access: RTL and testbench

Memory-stage data-memory access unit for the pipelined MIPS core. It consumes the M-stage decode (`L_M`, `DMWr`, `BESel`, `BExtOP`), the effective address and the store data. It drives a single-outstanding, ack-handshaked data bus with word-aligned address, byte lanes and lane-replicated write data. It returns sign- or zero-extended load data to the M/W pipeline register and holds the pipeline with `stall` until the access completes or times out.

---
 rtl/dm_access.sv | 173 +++++++++++++++++
 tb/tb_dm_access.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_access.sv
// ============================================================================
//  Module   : dm_access
//  Purpose  : M-stage data-memory access unit. Single-outstanding ack bus,
//             byte lanes, lane-replicated stores and extended loads.
//             Optional macro DM_ALIGN_CHECK_EN enables misalignment trapping.
//             Encodings: besel B=00 H=01 W=10 (11 acts as W),
//             bextop ZERO=0 SIGN=1.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dm_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic        st,
  input  logic [1:0]  besel,
  input  logic        bextop,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err
);

  localparam logic [1:0] c_BESEL_B    = 2'b00;
  localparam logic [1:0] c_BESEL_H    = 2'b01;
  localparam logic       c_BEXTOP_SGN = 1'b1;
  localparam logic [7:0] c_TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_besel;
  logic        r_bextop;
  logic [1:0]  r_off;

  logic        w_misalign;
  logic        w_issue;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_data;

`ifdef DM_ALIGN_CHECK_EN
  always_comb begin
    w_misalign = 1'b0;
    if (besel == c_BESEL_H)
      w_misalign = addr[0];
    else if (besel != c_BESEL_B)
      w_misalign = (addr[1:0] != 2'b00);
  end
  assign align_err = rst & (ld | st) & w_misalign;
`else
  assign w_misalign = 1'b0;
  assign align_err  = 1'b0;
`endif

  assign w_issue = (r_state == S_IDLE) && (ld | st) && !w_misalign;
  assign stall   = rst & (w_issue | (r_state == S_BUSY));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wd;
    case (besel)
      c_BESEL_B: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{wd[7:0]}};
      end
      c_BESEL_H: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wd[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset captured at issue, not the live address.
  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_off)
      2'd1:    w_byte = bus_rdata[15:8];
      2'd2:    w_byte = bus_rdata[23:16];
      2'd3:    w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half    = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    w_ld_data = bus_rdata;
    case (r_besel)
      c_BESEL_B: w_ld_data = (r_bextop == c_BEXTOP_SGN) ?
                             {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      c_BESEL_H: w_ld_data = (r_bextop == c_BEXTOP_SGN) ?
                             {{16{w_half[15]}}, w_half} : {16'd0, w_half};
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_besel   <= 2'b00;
      r_bextop  <= 1'b0;
      r_off     <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= 32'd0;
      bus_wdata <= 32'd0;
      rdata     <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            bus_req   <= 1'b1;
            bus_we    <= st;
            bus_be    <= w_be;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wdata <= w_wdata;
            r_besel   <= besel;
            r_bextop  <= bextop;
            r_off     <= addr[1:0];
            r_cnt     <= 8'd0;
            r_state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we)
              rdata <= w_ld_data;
            r_state <= S_DONE;
          end else if (r_cnt == c_TMO_LAST) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            rdata   <= 32'd0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_access.sv
// ============================================================================
//  Module   : tb_dm_access
//  Purpose  : Self-checking bench for dm_access: directed cases plus random
//             accesses against a behavioural bus/extension model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm_access;

  localparam int TMO = 4;

  logic        clk, rst, ld, st, bextop, bus_ack;
  logic [1:0]  besel;
  logic [31:0] addr, wd, bus_rdata;
  logic        bus_req, bus_we, stall, align_err, bus_err;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata, rdata;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_rdata = 32'd0;

  dm_access #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ld(ld), .st(st), .besel(besel), .bextop(bextop),
    .addr(addr), .wd(wd), .bus_req(bus_req), .bus_we(bus_we),
    .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .rdata(rdata), .stall(stall),
    .align_err(align_err), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_mis(input logic [1:0] bs, input logic [31:0] a);
`ifdef DM_ALIGN_CHECK_EN
    if (bs == 2'd1) return (a % 2) != 0;
    if (bs == 2'd0) return 1'b0;
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_be(input logic [1:0] bs, input logic [31:0] a);
    int off = int'(a % 4);
    if (bs == 2'd0) return 32'(1 << off);
    if (bs == 2'd1) return (off >= 2) ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] bs, input logic [31:0] d);
    if (bs == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (bs == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] bs, input logic bx,
                                             input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int off = int'(a % 4);
    if (bs == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (bx && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (bs == 2'd1) begin
      v = (w >> (16 * (off / 2))) & 32'hFFFF;
      if (bx && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // delay = BUSY cycles without ack before the ack cycle; >= TMO means no ack.
  task automatic do_access(input logic l, input logic s, input logic [1:0] bs,
                           input logic bx, input logic [31:0] a, input logic [31:0] d,
                           input int delay, input logic [31:0] word);
    logic mis;
    logic we;
    int k;
    mis = model_mis(bs, a);
    we  = s;
    @(negedge clk);
    ld = l; st = s; besel = bs; bextop = bx; addr = a; wd = d;
    #1;
    check("align_err", {31'd0, align_err}, {31'd0, mis});
    check("stall_T", {31'd0, stall}, {31'd0, !mis});
    if (mis) begin
      @(posedge clk); #1;
      check("mis_no_req", {31'd0, bus_req}, 32'd0);
      check("mis_stall", {31'd0, stall}, 32'd0);
      ld = 1'b0; st = 1'b0;
      return;
    end
    @(posedge clk); #1;
    check("bus_we", {31'd0, bus_we}, {31'd0, we});
    check("bus_be", {28'd0, bus_be}, model_be(bs, a));
    check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
    check("bus_wdata", bus_wdata, model_wdata(bs, d));
    k = 0;
    forever begin
      check("busy_req", {31'd0, bus_req}, 32'd1);
      check("busy_stall", {31'd0, stall}, 32'd1);
      if (k == delay) begin
        bus_ack = 1'b1; bus_rdata = word;
      end else begin
        bus_rdata = $urandom;
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (k == delay || k == TMO - 1) break;
      k++;
    end
    if (k == delay) begin
      if (!we) exp_rdata = model_load(bs, bx, a, word);
    end else begin
      exp_rdata = 32'd0;
    end
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_req", {31'd0, bus_req}, 32'd0);
    check("done_buserr", {31'd0, bus_err}, {31'd0, (k != delay)});
    check("done_rdata", rdata, exp_rdata);
    ld = 1'b0; st = 1'b0;
    @(posedge clk); #1;
    check("idle_buserr", {31'd0, bus_err}, 32'd0);
    check("idle_rdata", rdata, exp_rdata);
  endtask

  initial begin
    rst = 1'b0; ld = 1'b1; st = 1'b0; besel = 2'd1; bextop = 1'b0;
    addr = 32'h101; wd = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_align", {31'd0, align_err}, 32'd0);
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_be", {28'd0, bus_be}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_buserr", {31'd0, bus_err}, 32'd0);
    ld = 1'b0;
    @(negedge clk); rst = 1'b1;

    // LW, ack at T+1
    do_access(1, 0, 2'd2, 0, 32'h100, 32'd0, 0, 32'h8000_00FF);
    // LB sign / LBU at byte 3
    do_access(1, 0, 2'd0, 1, 32'h103, 32'd0, 3, 32'h8012_3456);
    do_access(1, 0, 2'd0, 0, 32'h103, 32'd0, 3, 32'h8012_3456);
    // SH upper half, rdata untouched
    do_access(0, 1, 2'd1, 0, 32'h202, 32'h1234_ABCD, 1, 32'hDEAD_BEEF);
    // ld&st together behaves as a store
    do_access(1, 1, 2'd0, 0, 32'h301, 32'h0000_0077, 0, 32'h1111_1111);
    // LH sign from low half
    do_access(1, 0, 2'd1, 1, 32'h400, 32'd0, 2, 32'h0000_9ABC);
    // timeout, then ack on the last allowed wait cycle
    do_access(1, 0, 2'd2, 0, 32'h500, 32'd0, TMO, 32'h1234_5678);
    do_access(1, 0, 2'd2, 0, 32'h504, 32'd0, TMO - 1, 32'hCAFE_F00D);
    // misaligned LH (trapped or truncated depending on build)
    do_access(1, 0, 2'd1, 0, 32'h101, 32'd0, 0, 32'h5555_AAAA);

    // asynchronous reset mid-access
    do_access(1, 0, 2'd2, 0, 32'h600, 32'd0, 0, 32'h0BAD_F00D);
    @(negedge clk);
    ld = 1'b1; st = 1'b0; besel = 2'd2; addr = 32'h700;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_req", {31'd0, bus_req}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    exp_rdata = 32'd0;
    ld = 1'b0;
    @(negedge clk); rst = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("late_ack_req", {31'd0, bus_req}, 32'd0);
    check("late_ack_rdata", rdata, 32'd0);
    do_access(1, 0, 2'd2, 0, 32'h700, 32'd0, 1, 32'h7777_0001);

    for (int i = 0; i < 60; i++) begin
      logic lr, sr;
      lr = 1'($urandom);
      sr = !lr | (($urandom % 8) == 0);
      do_access(lr, sr, 2'($urandom_range(0, 2)), 1'($urandom), $urandom, $urandom,
                int'($urandom_range(0, TMO)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
